lidar_frame_parser: RTL
=======================

LIDAR_FRAME_PARSER -- requirements
Module: lidar_frame_parser

Interface
REQ-001 SHALL have parameter HEADER_BYTE, default 8'h59, the frame sync byte, which appears twice at the start of each frame.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, the maximum idle clk_in cycles allowed between bytes inside a frame.
REQ-003 SHALL have port clk_in, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port byte_in, input, 8 bits: received UART byte.
REQ-006 SHALL have port byte_valid_in, input, 1 bit: byte_in is valid this cycle (single-cycle strobe).
REQ-007 SHALL have port distance_out, output, 16 bits: last validated distance.
REQ-008 SHALL have port strength_out, output, 16 bits: last validated signal strength.
REQ-009 SHALL have port temperature_out, output, 16 bits: last validated temperature.
REQ-010 SHALL have port data_valid_out, output, 1 bit: one-cycle pulse when a new validated frame is presented.
REQ-011 SHALL have port checksum_err_out, output, 1 bit: one-cycle pulse on checksum mismatch.
REQ-012 SHALL have port timeout_err_out, output, 1 bit: one-cycle pulse on inter-byte timeout.
REQ-013 SHALL have port err_count_out, output, 8 bits: count of checksum errors, saturating.

Function
REQ-014 SHALL parse a 9-byte frame: HDR, HDR, Dist_L, Dist_H, Str_L, Str_H, Temp_L, Temp_H, CSUM. All fields are little-endian.
REQ-015 SHALL act only in cycles where byte_valid_in=1; all other cycles SHALL leave the state and data unchanged, except for timeout counting.
REQ-016 SHALL implement these FSM states and transitions:
- S_HDR1: byte==HEADER_BYTE -> S_HDR2; else stay in S_HDR1.
- S_HDR2: byte==HEADER_BYTE -> S_PAYLOAD; else -> S_HDR1.
- S_PAYLOAD: store the byte at index idx (0..5) and increment idx; on idx==5 -> S_CSUM.
- S_CSUM: compare the byte with the running sum, then -> S_HDR1.
REQ-017 SHALL treat a third consecutive HEADER_BYTE as Dist_L; there is no header re-sync inside S_PAYLOAD.
REQ-018 SHALL compute the checksum as the low 8 bits of the modulo-256 sum of bytes 0..7, including both header bytes; wrap-around is intended.
REQ-019 SHALL, on checksum match, update distance/strength/temperature_out and pulse data_valid_out in the cycle after the CSUM byte is accepted (1-cycle latency).
REQ-020 SHALL, on checksum mismatch, hold the data outputs, pulse checksum_err_out with 1-cycle latency, and increment err_count_out, saturating at 8'hFF.
REQ-021 SHALL never assert data_valid_out and checksum_err_out in the same cycle.
REQ-022 SHALL accept a new header byte in the cycle immediately following the CSUM byte, with no dead cycles between frames.

Reset
REQ-023 SHALL, while rst_in=1 at a clk_in edge, set state=S_HDR1, idx=0, sum=0, timer=0, all data outputs=0, all pulses=0, err_count_out=0.
REQ-024 SHALL, on reset mid-frame, discard the partial frame with no error pulse.

Configuration
REQ-025 SHALL use macro LIDAR_TIMEOUT_EN to enable the inter-byte timeout.
- Defined: in any state other than S_HDR1, the timer increments on every cycle without byte_valid_in and clears on every accepted byte. When timer reaches TIMEOUT_CYCLES-1 the block returns to S_HDR1, clears the sum and pulses timeout_err_out for one cycle.
- Not defined: no timer is built, timeout_err_out is tied to 0, and a partial frame waits indefinitely.
REQ-026 SHALL, if a byte arrives in the same cycle the timeout would fire, let the byte win: it is processed and the timer clears.

Structure
REQ-027 SHALL place the state enum (S_HDR1, S_HDR2, S_PAYLOAD, S_CSUM), the frame length constant (9) and the default HEADER_BYTE in shared package lidar_pkg.
REQ-028 SHALL use one sub-module, lidar_sum_accum: an 8-bit running-sum accumulator with clear and add-enable inputs, instantiated by the parser.

Verification
REQ-029 SHALL cover: 59 59 2C 01 10 27 00 09 1F -> data_valid_out pulse, distance=300, strength=10000, temperature=16'h0900.
REQ-030 SHALL cover: the same frame with CSUM=20 -> checksum_err_out pulse, outputs held at previous values, err_count_out=1.
REQ-031 SHALL cover: 00 59 00 followed by the valid frame of REQ-029 -> no pulses until the valid frame completes, then a single data_valid_out pulse.
REQ-032 SHALL cover (LIDAR_TIMEOUT_EN): 59 59 2C, then TIMEOUT_CYCLES idle cycles -> timeout_err_out pulse; a following valid frame then parses correctly.
REQ-033 SHALL cover: rst_in asserted after byte 4 of a frame, then the full valid frame -> no error pulse, one data_valid_out pulse.
REQ-034 SHALL cover: 256 bad frames -> err_count_out saturates at 255.

Source files
------------

// File: rtl/lidar_pkg.sv
// Shared definitions for the lidar frame parser: FSM states, frame geometry
// and the default sync byte.
package lidar_pkg;

  typedef enum logic [1:0] {
    S_HDR1    = 2'd0,
    S_HDR2    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CSUM    = 2'd3
  } lidar_state_e;

  // HDR, HDR, 6 payload bytes, CSUM
  localparam int         LIDAR_FRAME_LEN   = 9;
  localparam int         LIDAR_PAYLOAD_LEN = 6;
  localparam logic [7:0] LIDAR_HDR_DEFAULT = 8'h59;

endpackage

// File: rtl/lidar_frame_parser_if.sv
// Byte-stream and result bundle for the lidar frame parser. The master side
// (UART/bench) sources bytes and consumes results; the slave side is the parser.
interface lidar_frame_parser_if;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic [15:0] distance;
  logic [15:0] strength;
  logic [15:0] temperature;
  logic        data_valid;
  logic        checksum_err;
  logic        timeout_err;
  logic [7:0]  err_count;

  modport master (
    output byte_in, byte_valid_in,
    input  distance, strength, temperature,
    input  data_valid, checksum_err, timeout_err, err_count
  );

  modport slave (
    input  byte_in, byte_valid_in,
    output distance, strength, temperature,
    output data_valid, checksum_err, timeout_err, err_count
  );
endinterface

// File: rtl/lidar_sum_accum.sv
// 8-bit modulo-256 running-sum accumulator. Clear has priority over add;
// clear with add loads the incoming byte so a frame's first header byte
// can start a fresh sum in the same cycle.
module lidar_sum_accum (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] data_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;

  // Running sum; wrap-around is the intended checksum arithmetic.
  always_ff @(posedge clk_i) begin
    if (rst_i)      sum_q <= 8'h00;
    else if (clr_i) sum_q <= add_i ? data_i : 8'h00;
    else if (add_i) sum_q <= sum_q + data_i;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/lidar_frame_parser.sv
// 9-byte lidar frame parser: HDR HDR DL DH SL SH TL TH CSUM (little-endian).
// Optional inter-byte timeout is built only when LIDAR_TIMEOUT_EN is defined;
// otherwise timeout_err_out stays 0 and partial frames wait indefinitely.
module lidar_frame_parser
  import lidar_pkg::*;
#(
  parameter logic [7:0] HEADER_BYTE    = LIDAR_HDR_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid_in,
  output logic [15:0] distance_out,
  output logic [15:0] strength_out,
  output logic [15:0] temperature_out,
  output logic        data_valid_out,
  output logic        checksum_err_out,
  output logic        timeout_err_out,
  output logic [7:0]  err_count_out
);

  lidar_state_e state_q;
  logic [2:0]   idx_q;
  logic [LIDAR_PAYLOAD_LEN-1:0][7:0] pay_q;  // pay_q[0] = Dist_L once full
  logic [15:0]  dist_q, str_q, temp_q;
  logic         dv_q, cerr_q, terr_q;
  logic [7:0]   ecnt_q;

  logic         acc_clr, acc_add;
  logic [7:0]   sum;
  logic         tmo_fire;
  logic         is_hdr;

  assign is_hdr = (byte_in == HEADER_BYTE);

`ifdef LIDAR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer_q;

  // A byte in the firing cycle wins, so fire only on idle cycles mid-frame.
  assign tmo_fire = (state_q != S_HDR1) && !byte_valid_in && (timer_q == T_LAST);

  // Idle-cycle counter; cleared by any accepted byte, while hunting, or on fire.
  always_ff @(posedge clk_in) begin
    if (rst_in)                                           timer_q <= '0;
    else if (byte_valid_in || state_q == S_HDR1 || tmo_fire) timer_q <= '0;
    else                                                  timer_q <= timer_q + TW'(1);
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Accumulator control: sum holds bytes 0..7 of the frame in progress.
  always_comb begin
    acc_clr = 1'b0;
    acc_add = 1'b0;
    if (byte_valid_in) begin
      unique case (state_q)
        S_HDR1: begin
          acc_clr = 1'b1;
          acc_add = is_hdr;
        end
        S_HDR2: begin
          acc_add = is_hdr;
          acc_clr = !is_hdr;
        end
        S_PAYLOAD: acc_add = 1'b1;
        S_CSUM:    acc_clr = 1'b1;
        default:   acc_clr = 1'b1;
      endcase
    end else if (tmo_fire) begin
      acc_clr = 1'b1;
    end
  end

  lidar_sum_accum u_sum (
    .clk_i  (clk_in),
    .rst_i  (rst_in),
    .clr_i  (acc_clr),
    .add_i  (acc_add),
    .data_i (byte_in),
    .sum_o  (sum)
  );

  // Frame FSM with registered result and pulse outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_HDR1;
      idx_q   <= 3'd0;
      pay_q   <= '0;
      dist_q  <= 16'h0000;
      str_q   <= 16'h0000;
      temp_q  <= 16'h0000;
      dv_q    <= 1'b0;
      cerr_q  <= 1'b0;
      terr_q  <= 1'b0;
      ecnt_q  <= 8'h00;
    end else begin
      dv_q   <= 1'b0;
      cerr_q <= 1'b0;
      terr_q <= 1'b0;
      if (byte_valid_in) begin
        unique case (state_q)
          S_HDR1: if (is_hdr) state_q <= S_HDR2;
          S_HDR2: begin
            state_q <= is_hdr ? S_PAYLOAD : S_HDR1;
            idx_q   <= 3'd0;
          end
          S_PAYLOAD: begin
            // No re-sync here: header-valued bytes are ordinary payload.
            pay_q <= {byte_in, pay_q[LIDAR_PAYLOAD_LEN-1:1]};
            if (idx_q == 3'd5) begin
              idx_q   <= 3'd0;
              state_q <= S_CSUM;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
          S_CSUM: begin
            if (byte_in == sum) begin
              dist_q <= {pay_q[1], pay_q[0]};
              str_q  <= {pay_q[3], pay_q[2]};
              temp_q <= {pay_q[5], pay_q[4]};
              dv_q   <= 1'b1;
            end else begin
              cerr_q <= 1'b1;
              if (ecnt_q != 8'hFF) ecnt_q <= ecnt_q + 8'd1;
            end
            state_q <= S_HDR1;
          end
          default: state_q <= S_HDR1;
        endcase
      end else if (tmo_fire) begin
        state_q <= S_HDR1;
        idx_q   <= 3'd0;
        terr_q  <= 1'b1;
      end
    end
  end

  assign distance_out     = dist_q;
  assign strength_out     = str_q;
  assign temperature_out  = temp_q;
  assign data_valid_out   = dv_q;
  assign checksum_err_out = cerr_q;
  assign timeout_err_out  = terr_q;
  assign err_count_out    = ecnt_q;

endmodule
